// File: rtl/reg_cmd_generator.sv
// ---------------------------------------------------------------------------
// reg_cmd_generator
//
// Turns four raw push buttons into single-cycle command codes for the
// downstream register block. Each button is synchronised (two flops),
// debounced (a level change must persist DEBOUNCE_CYCLES synced cycles) and
// edge-detected on press. Simultaneous press edges are arbitrated
// CLR > LD > DEC > INC. INC and DEC auto-repeat while held: the first
// repeat comes REPEAT_DELAY cycles after the initial pulse, then one pulse
// every REPEAT_PERIOD cycles.
//
// Ports:
//   clk          system clock, rising edge
//   async_reset  active-high reset, asynchronous assert
//   btn_inc      raw increment button (active-high, asynchronous)
//   btn_dec      raw decrement button (active-high, asynchronous)
//   btn_ld       raw load button (active-high, asynchronous)
//   btn_clr      raw clear button (active-high, asynchronous)
//   ctrl         registered command code to the register block
//   cmd_valid    high exactly when ctrl != REG_CTRL_NONE
//
// The REG_CTRL_* parameters must match the encodings used by the register
// block.
// ---------------------------------------------------------------------------
module reg_cmd_generator #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4,
    parameter int CNT_WIDTH       = 20,
    parameter int REG_CTRL_WIDTH  = 3,
    parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_NONE = 3'd0,
    parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_INC  = 3'd1,
    parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_DEC  = 3'd2,
    parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_LD   = 3'd3,
    parameter logic [REG_CTRL_WIDTH-1:0] REG_CTRL_CLR  = 3'd4
) (
    input  logic                      clk,
    input  logic                      async_reset,
    input  logic                      btn_inc,
    input  logic                      btn_dec,
    input  logic                      btn_ld,
    input  logic                      btn_clr,
    output logic [REG_CTRL_WIDTH-1:0] ctrl,
    output logic                      cmd_valid
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REP_DELAY = CNT_WIDTH'(REPEAT_DELAY);
    localparam logic [CNT_WIDTH-1:0] REP_PER   = CNT_WIDTH'(REPEAT_PERIOD);

    // Button index: 0 = INC, 1 = DEC, 2 = LD, 3 = CLR.
    localparam int B_INC = 0;
    localparam int B_DEC = 1;
    localparam int B_LD  = 2;
    localparam int B_CLR = 3;

    logic [3:0] btn_raw;
    logic [3:0] db_lvl;

    assign btn_raw = {btn_clr, btn_ld, btn_dec, btn_inc};

    // -----------------------------------------------------------------------
    // Per-button synchroniser and debouncer
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic                 sync1_q;
            logic                 sync2_q;
            logic                 db_q;
            logic                 db_d;
            logic [CNT_WIDTH-1:0] cnt_q;
            logic [CNT_WIDTH-1:0] cnt_d;

            // The counter only runs while the synced level disagrees with the
            // accepted level; any agreeing cycle restarts the qualification.
            always_comb begin
                db_d  = db_q;
                cnt_d = '0;
                if (sync2_q != db_q) begin
                    if (cnt_q == DB_LAST) begin
                        db_d  = sync2_q;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            always_ff @(posedge clk or posedge async_reset) begin
                if (async_reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    db_q    <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    db_q    <= db_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign db_lvl[gi] = db_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Press-edge detection
    // -----------------------------------------------------------------------
    logic [3:0] db_prev_q;
    logic [3:0] press;

    assign press = db_lvl & ~db_prev_q;

    // -----------------------------------------------------------------------
    // Arbitration, repeat FSM and command register
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_HOLD_WAIT = 2'd1,
        S_REPEAT    = 2'd2
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [CNT_WIDTH-1:0]      rep_cnt_q;
    logic [CNT_WIDTH-1:0]      rep_cnt_d;
    logic                      rep_sel_q;    // 0 = INC, 1 = DEC
    logic                      rep_sel_d;
    logic [REG_CTRL_WIDTH-1:0] ctrl_q;
    logic [REG_CTRL_WIDTH-1:0] ctrl_d;
    logic                      cmd_valid_q;
    logic                      cmd_valid_d;
    logic                      rep_held;
    logic                      other_held;

    always_comb begin
        state_d     = state_q;
        rep_cnt_d   = rep_cnt_q;
        rep_sel_d   = rep_sel_q;
        ctrl_d      = REG_CTRL_NONE;
        cmd_valid_d = 1'b0;

        rep_held   = rep_sel_q ? db_lvl[B_DEC] : db_lvl[B_INC];
        other_held = db_lvl[B_LD] | db_lvl[B_CLR] |
                     (rep_sel_q ? db_lvl[B_INC] : db_lvl[B_DEC]);

        if (press[B_CLR]) begin
            ctrl_d      = REG_CTRL_CLR;
            cmd_valid_d = 1'b1;
            state_d     = S_IDLE;
        end else if (press[B_LD]) begin
            ctrl_d      = REG_CTRL_LD;
            cmd_valid_d = 1'b1;
            state_d     = S_IDLE;
        end else if (press[B_DEC] || press[B_INC]) begin
            ctrl_d      = press[B_DEC] ? REG_CTRL_DEC : REG_CTRL_INC;
            cmd_valid_d = 1'b1;
            if (state_q == S_IDLE) begin
                state_d   = S_HOLD_WAIT;
                rep_cnt_d = REP_DELAY;
                rep_sel_d = press[B_DEC];
            end else begin
                // Second INC/DEC button while repeating: one shot, no repeat.
                state_d = S_IDLE;
            end
        end else if (state_q != S_IDLE) begin
            if (!rep_held || other_held) begin
                state_d = S_IDLE;
            end else if (rep_cnt_q <= CNT_ONE) begin
                // Counter reaches zero on this cycle: issue and reload.
                ctrl_d      = rep_sel_q ? REG_CTRL_DEC : REG_CTRL_INC;
                cmd_valid_d = 1'b1;
                rep_cnt_d   = REP_PER;
                state_d     = S_REPEAT;
            end else begin
                rep_cnt_d = rep_cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            db_prev_q   <= 4'b0000;
            state_q     <= S_IDLE;
            rep_cnt_q   <= '0;
            rep_sel_q   <= 1'b0;
            ctrl_q      <= REG_CTRL_NONE;
            cmd_valid_q <= 1'b0;
        end else begin
            db_prev_q   <= db_lvl;
            state_q     <= state_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_sel_q   <= rep_sel_d;
            ctrl_q      <= ctrl_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign ctrl      = ctrl_q;
    assign cmd_valid = cmd_valid_q;

endmodule
